// File: rtl/ipml_prefetch_fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock prefetch FIFO.
package ipml_prefetch_fifo_pkg;

  typedef enum logic [1:0] {
    OS_EMPTY = 2'd0,
    OS_ONE   = 2'd1,
    OS_TWO   = 2'd2
  } os_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic bit fifo_params_ok(input int unsigned data_w,
                                        input int unsigned depth_w,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
    if (data_w < 1 || data_w > 1152) return 1'b0;
    if (depth_w < 2 || depth_w > 16) return 1'b0;
    if (af_level < 1 || af_level > (32'd1 << depth_w)) return 1'b0;
    if (ae_level > (32'd1 << depth_w) - 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/ipml_fwft_out_stage.sv
// Two-entry first-word-fall-through output register; out_data is always the oldest entry.
module ipml_fwft_out_stage
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  os_state_t         state, state_nxt;
  logic [DATA_W-1:0] head, tail;
  logic              take, drop;

  assign take = in_valid & ~flush;
  assign drop = pop & ~flush & (state != OS_EMPTY);

  always_comb begin
    state_nxt = state;
    unique case (state)
      OS_EMPTY: if (take) state_nxt = OS_ONE;
      OS_ONE: begin
        if (take && !drop)      state_nxt = OS_TWO;
        else if (drop && !take) state_nxt = OS_EMPTY;
      end
      OS_TWO:   if (drop) state_nxt = OS_ONE;
      default:  state_nxt = OS_EMPTY;
    endcase
    if (flush) state_nxt = OS_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OS_EMPTY;
    else     state <= state_nxt;
  end

  // head is not cleared by flush so the last visible word stays on out_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      unique case (state)
        OS_EMPTY: if (take) head <= in_data;
        OS_ONE: begin
          if (take && drop) head <= in_data;
          else if (take)    tail <= in_data;
        end
        OS_TWO: begin
          if (drop) begin
            head <= tail;
            if (take) tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state != OS_EMPTY);
  assign out_data  = head;
  assign occupancy = state;

endmodule

// File: rtl/ipml_prefetch_fifo_sync_v2_0.sv
// Single-clock prefetch FIFO: registered-read RAM feeding a 2-entry FWFT output stage.
module ipml_prefetch_fifo_sync_v2_0
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH_W  = 9,
  parameter int unsigned AF_LEVEL = 2**DEPTH_W - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_en,
  output logic               wr_vld,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               rd_en,
  output logic               rd_vld,
  output logic [DEPTH_W:0]   data_count,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned CAP = 2**DEPTH_W;
  localparam logic [DEPTH_W:0] CAP_C = (DEPTH_W+1)'(CAP);
  localparam logic [DEPTH_W:0] AF_C  = (DEPTH_W+1)'(AF_LEVEL);
  localparam logic [DEPTH_W:0] AE_C  = (DEPTH_W+1)'(AE_LEVEL);

  if (!fifo_params_ok(DATA_W, DEPTH_W, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("ipml_prefetch_fifo_sync_v2_0: illegal DATA_W/DEPTH_W/AF_LEVEL/AE_LEVEL");
  end

  logic [DATA_W-1:0] ram [CAP];
  logic [DATA_W-1:0] ram_q;
  logic [DEPTH_W:0]  wr_ptr, rd_ptr, count, cnt_nxt;
  logic              inflight, ram_empty, wr_acc, pop, issue;
  logic [1:0]        occ;
  logic [2:0]        stage_load;

  assign wr_vld    = (count != CAP_C);
  assign wr_acc    = wr_en & wr_vld;
  assign pop       = rd_en & rd_vld;
  assign ram_empty = (wr_ptr == rd_ptr);

  // Entries the output stage will hold after this edge if no new read is issued.
  assign stage_load = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = !ram_empty && (stage_load < 3'd2);

  assign cnt_nxt = count + (DEPTH_W+1)'(wr_acc) - (DEPTH_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_acc && !flush) ram[wr_ptr[DEPTH_W-1:0]] <= wr_data;
    if (issue)            ram_q <= ram[rd_ptr[DEPTH_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= 1'b0;
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= 1'b0;
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (issue)  rd_ptr <= rd_ptr + 1'b1;
      inflight     <= issue;
      count        <= cnt_nxt;
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      if (wr_en && !wr_vld) overflow  <= 1'b1;
      if (rd_en && !rd_vld) underflow <= 1'b1;
    end
  end

  ipml_fwft_out_stage #(.DATA_W(DATA_W)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (inflight),
    .in_data   (ram_q),
    .pop       (pop),
    .out_valid (rd_vld),
    .out_data  (rd_data),
    .occupancy (occ)
  );

  assign data_count = count;

endmodule

// File: tb/tb_ipml_prefetch_fifo_sync_v2_0.sv
// Self-checking bench: directed table, corner sequences and random traffic against a queue model.
module tb_ipml_prefetch_fifo_sync_v2_0;

  localparam int unsigned DW  = 16;
  localparam int unsigned DPW = 4;
  localparam int unsigned CAP = 16;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
  logic [DPW:0]  data_count;

  ipml_prefetch_fifo_sync_v2_0 #(
    .DATA_W(DW), .DEPTH_W(DPW), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .wr_vld(wr_vld), .rd_data(rd_data), .rd_en(rd_en), .rd_vld(rd_vld),
    .data_count(data_count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: every accepted word with the edge index at which it was accepted.
  // A word is visible at the head two edges after acceptance.
  typedef struct { logic [DW-1:0] d; int unsigned t; } ent_t;
  ent_t        mq[$];
  int unsigned cyc = 0;
  logic        m_ovf = 1'b0, m_udf = 1'b0;

  typedef struct {
    logic          we; logic [DW-1:0] wd; logic re; logic fl;
    logic          vld; logic [DW-1:0] data; logic [DPW:0] cnt; logic udf; logic ae;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit m_vld();
    return (mq.size() > 0) && (cyc >= mq[0].t + 2);
  endfunction

  task automatic compare_model();
    chk("rd_vld", rd_vld, m_vld());
    chk("wr_vld", wr_vld, mq.size() != CAP);
    chk("data_count", data_count, mq.size());
    chk("almost_full", almost_full, mq.size() >= 14);
    chk("almost_empty", almost_empty, mq.size() <= 2);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    if (m_vld()) chk("rd_data", rd_data, mq[0].d);
  endtask

  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
    bit wv, rv;
    wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    wv = (mq.size() != CAP);
    rv = m_vld();
    @(posedge clk);
    #1;
    cyc++;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (we && !wv) m_ovf = 1'b1;
      if (re && !rv) m_udf = 1'b1;
      if (re && rv) void'(mq.pop_front());
      if (we && wv) mq.push_back('{d: wd, t: cyc});
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    compare_model();
  endtask

  initial begin
    int unsigned maxc;
    logic [DW-1:0] held;

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_wr_vld", wr_vld, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", data_count, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst = 1'b0;

    tbl[0] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5, 5'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].fl);
      chk($sformatf("tbl%0d_vld", i), rd_vld, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].data);
      chk($sformatf("tbl%0d_cnt", i), data_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_udf", i), underflow, tbl[i].udf);
      chk($sformatf("tbl%0d_ae", i), almost_empty, tbl[i].ae);
    end

    // Fill to full, then one write too many.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'h0BAD, 1'b0, 1'b0);
    chk("full_cnt", data_count, 16);
    chk("full_wr_vld", wr_vld, 0);
    chk("full_af", almost_full, 1);
    chk("full_ovf", overflow, 1);
    chk("full_head", rd_data, 16'h0000);

    // Drain with rd_en held, including one pop past empty.
    for (int i = 0; i < 16; i++) begin
      chk("drain_vld", rd_vld, 1);
      chk("drain_data", rd_data, 16'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_cnt", data_count, 0);
    chk("drain_udf", underflow, 1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Streaming through pointer wrap.
    maxc = 0;
    for (int i = 0; i < 104; i++) begin
      cycle(i < 100, 16'(16'h4000 + i), 1'b1, 1'b0);
      if (32'(data_count) > maxc) maxc = 32'(data_count);
    end
    chk("stream_max_cnt_le3", 32'(maxc <= 3), 1);
    chk("stream_empty", data_count, 0);

    // Flush colliding with write and pop; head word stays on rd_data.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0050 + i), 1'b0, 1'b0);
    cycle(1'b1, '0, 1'b1, 1'b0);
    cycle(1'b1, '0, 1'b1, 1'b0);
    held = rd_data;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    held = rd_data;
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
    chk("flush_cnt", data_count, 0);
    chk("flush_rd_vld", rd_vld, 0);
    chk("flush_wr_vld", wr_vld, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_udf", underflow, 0);
    chk("flush_hold", rd_data, held);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);

    // Random traffic with varying bias and occasional flushes.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        logic we, re, fl;
        we = ($urandom_range(0, 3) < 32'(ph + 1)) || (ph == 3 && i < 30);
        re = ($urandom_range(0, 3) < 32'(3 - ph)) && !(ph == 3 && i < 30);
        fl = ($urandom_range(0, 99) == 0);
        cycle(we, 16'($urandom), re, fl);
      end
    end

    // Asynchronous reset while a RAM read is in flight.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0077, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_vld", rd_vld, 0);
    chk("arst_wr_vld", wr_vld, 1);
    chk("arst_count", data_count, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_ae", almost_empty, 1);
    #1 rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("arst_after1_vld", rd_vld, 0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("arst_new_vld", rd_vld, 1);
    chk("arst_new_data", rd_data, 16'h1234);
    chk("arst_new_cnt", data_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
